// File: rtl/song_player_ctrl_pkg.sv
// Shared constants for the music-box playback sequencer: note word layout,
// special words and FSM state encodings.
package music_pkg;

    localparam int NOTE_W = 6;
    localparam int DUR_W  = 4;
    localparam int WORD_W = NOTE_W + DUR_W;

    localparam logic [NOTE_W-1:0] REST     = 6'd0;
    localparam logic [WORD_W-1:0] END_WORD = 10'd0;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_FETCH = 3'd1;
    localparam state_t ST_WAIT  = 3'd2;
    localparam state_t ST_PLAY  = 3'd3;
    localparam state_t ST_GAP   = 3'd4;
    localparam state_t ST_PAUSE = 3'd5;

    function automatic logic [NOTE_W-1:0] word_note(input logic [WORD_W-1:0] w);
        return w[WORD_W-1:DUR_W];
    endfunction

    // A zero duration on a real note would otherwise underflow the beat counter.
    function automatic logic [DUR_W-1:0] word_dur(input logic [WORD_W-1:0] w);
        logic [DUR_W-1:0] d;
        d = w[DUR_W-1:0];
        return (d == 4'd0) ? 4'd1 : d;
    endfunction

endpackage

// File: rtl/song_player_ctrl_if.sv
// Control, song-ROM and tone-generator signals of the playback sequencer.
// master = controlling side (buttons, ROM), slave = song_player_ctrl.
interface song_player_ctrl_if
    import music_pkg::*;
#(
    parameter int IDX_W   = 8,
    parameter int SONG_AW = 6
);
    logic [IDX_W-1:0]         song_index;
    logic                     start;
    logic                     pause;
    logic                     stop;
    logic [IDX_W+SONG_AW-1:0] rom_addr;
    logic [WORD_W-1:0]        rom_data;
    logic [NOTE_W-1:0]        note_code;
    logic                     note_valid;
    logic                     playing;
    logic                     paused;
    logic                     done;

    modport master (
        output song_index, start, pause, stop, rom_data,
        input  rom_addr, note_code, note_valid, playing, paused, done
    );

    modport slave (
        input  song_index, start, pause, stop, rom_data,
        output rom_addr, note_code, note_valid, playing, paused, done
    );
endinterface

// File: rtl/song_player_ctrl_beat_timer.sv
// Per-note tick/beat timer: loaded with a beat count, frozen when disabled,
// flags the start of the articulation gap and the final tick of the note.
module beat_timer
    import music_pkg::*;
#(
    parameter int TICKS_PER_BEAT = 12_500_000,
    parameter int GAP_TICKS      = 1_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [DUR_W-1:0] i_dur,
    input  logic             i_en,
    output logic             o_gap_start,
    output logic             o_note_end
);
    localparam int TW = (TICKS_PER_BEAT > 1) ? $clog2(TICKS_PER_BEAT) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BEAT - 1);
    localparam logic [TW-1:0] GAP_AT    = TW'(TICKS_PER_BEAT - GAP_TICKS - 1);

    logic [TW-1:0]    r_tick;
    logic [DUR_W-1:0] r_beats;
    logic             w_last_beat;

    assign w_last_beat = (r_beats == DUR_W'(1));
    assign o_gap_start = w_last_beat && (r_tick == GAP_AT);
    assign o_note_end  = w_last_beat && (r_tick == TICK_LAST);

    // Tick counter wraps once per beat and decrements the remaining beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick  <= '0;
            r_beats <= '0;
        end else if (i_load) begin
            r_tick  <= '0;
            r_beats <= i_dur;
        end else if (i_en) begin
            if (r_tick == TICK_LAST) begin
                r_tick  <= '0;
                r_beats <= r_beats - DUR_W'(1);
            end else begin
                r_tick  <= r_tick + TW'(1);
            end
        end
    end

endmodule

// File: rtl/song_player_ctrl.sv
// Music-box playback sequencer: walks a song's note words and drives the tone generator.
// Define PLAYER_LOOP_EN to restart the song from note 0 instead of stopping at its end.
module song_player_ctrl
    import music_pkg::*;
#(
    parameter int TICKS_PER_BEAT = 12_500_000,
    parameter int GAP_TICKS      = 1_000_000,
    parameter int SONG_AW        = 6,
    parameter int IDX_W          = 8
) (
    input  logic              clk,
    input  logic              rst,
    song_player_ctrl_if.slave bus
);
    localparam logic [SONG_AW-1:0] PTR_LAST = {SONG_AW{1'b1}};

    state_t              r_state, r_saved;
    logic [IDX_W-1:0]    r_song;
    logic [SONG_AW-1:0]  r_ptr;
    logic [NOTE_W-1:0]   r_note;
    logic                r_valid, r_playing, r_paused, r_done;

    state_t              w_run_state, w_state_nxt, w_saved_nxt;
    logic [SONG_AW-1:0]  w_run_ptr, w_ptr_nxt;
    logic [NOTE_W-1:0]   w_run_note, w_note_nxt;
    logic [IDX_W-1:0]    w_song_nxt;
    logic                w_run_done, w_done_nxt, w_end, w_load, w_tmr_en;
    logic                w_gap_start, w_note_end;

    assign w_tmr_en = (r_state == ST_PLAY) || (r_state == ST_GAP);

    beat_timer #(
        .TICKS_PER_BEAT (TICKS_PER_BEAT),
        .GAP_TICKS      (GAP_TICKS)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_dur       (word_dur(bus.rom_data)),
        .i_en        (w_tmr_en),
        .o_gap_start (w_gap_start),
        .o_note_end  (w_note_end)
    );

    // Undisturbed playback progression, ignoring the button pulses.
    always_comb begin
        w_run_state = r_state;
        w_run_ptr   = r_ptr;
        w_run_note  = r_note;
        w_run_done  = 1'b0;
        w_end       = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE:  w_run_state = ST_IDLE;
            ST_FETCH: w_run_state = ST_WAIT;
            ST_WAIT: begin
                if (bus.rom_data == END_WORD) begin
                    w_end = 1'b1;
                end else begin
                    w_run_note  = word_note(bus.rom_data);
                    w_load      = 1'b1;
                    w_run_state = ST_PLAY;
                end
            end
            ST_PLAY:  w_run_state = w_gap_start ? ST_GAP : ST_PLAY;
            ST_GAP: begin
                if (w_note_end && (r_ptr == PTR_LAST)) begin
                    w_end = 1'b1;
                end else if (w_note_end) begin
                    w_run_ptr   = r_ptr + SONG_AW'(1);
                    w_run_state = ST_FETCH;
                end else begin
                    w_run_state = ST_GAP;
                end
            end
            ST_PAUSE: w_run_state = ST_PAUSE;
            default:  w_run_state = ST_IDLE;
        endcase
        if (w_end) begin
            w_run_done = 1'b1;
            w_run_ptr  = '0;
            w_run_note = REST;
`ifdef PLAYER_LOOP_EN
            w_run_state = ST_FETCH;
`else
            w_run_state = ST_IDLE;
`endif
        end else begin
            w_run_done = 1'b0;
        end
    end

    // Button arbitration: stop > start > pause. Pausing keeps this cycle's progress
    // and parks the state it would have entered, so a paused note sounds no longer.
    always_comb begin
        w_state_nxt = w_run_state;
        w_saved_nxt = r_saved;
        w_song_nxt  = r_song;
        w_ptr_nxt   = w_run_ptr;
        w_note_nxt  = w_run_note;
        w_done_nxt  = w_run_done;
        if (bus.stop) begin
            w_state_nxt = ST_IDLE;
            w_ptr_nxt   = '0;
            w_note_nxt  = REST;
            w_done_nxt  = 1'b0;
        end else if (bus.start) begin
            w_state_nxt = ST_FETCH;
            w_song_nxt  = bus.song_index;
            w_ptr_nxt   = '0;
            w_note_nxt  = REST;
            w_done_nxt  = 1'b0;
        end else if (bus.pause && (r_state == ST_PAUSE)) begin
            w_state_nxt = r_saved;
        end else if (bus.pause && (r_state != ST_IDLE) && (w_run_state != ST_IDLE)) begin
            w_state_nxt = ST_PAUSE;
            w_saved_nxt = w_run_state;
        end else begin
            w_state_nxt = w_run_state;
        end
    end

    // State and outputs, all registered from next-state values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_saved   <= ST_IDLE;
            r_song    <= '0;
            r_ptr     <= '0;
            r_note    <= REST;
            r_valid   <= 1'b0;
            r_playing <= 1'b0;
            r_paused  <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_saved   <= w_saved_nxt;
            r_song    <= w_song_nxt;
            r_ptr     <= w_ptr_nxt;
            r_note    <= w_note_nxt;
            r_valid   <= (w_state_nxt == ST_PLAY) && (w_note_nxt != REST);
            r_playing <= (w_state_nxt == ST_FETCH) || (w_state_nxt == ST_WAIT) ||
                         (w_state_nxt == ST_PLAY)  || (w_state_nxt == ST_GAP);
            r_paused  <= (w_state_nxt == ST_PAUSE);
            r_done    <= w_done_nxt;
        end
    end

    assign bus.rom_addr   = {r_song, r_ptr};
    assign bus.note_code  = r_note;
    assign bus.note_valid = r_valid;
    assign bus.playing    = r_playing;
    assign bus.paused     = r_paused;
    assign bus.done       = r_done;

endmodule

// File: tb/tb_song_player_ctrl.sv
// Directed bench for song_player_ctrl with TICKS_PER_BEAT=4, GAP_TICKS=1, SONG_AW=3.
module tb_song_player_ctrl;
    import music_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [9:0]  rom [0:2047];
    logic [63:0] v_valid, v_done, v_play, v_paused;
    logic [10:0] addr_log [0:63];
    logic [5:0]  code_log [0:63];

    song_player_ctrl_if #(.IDX_W(8), .SONG_AW(3)) bus ();

    song_player_ctrl #(
        .TICKS_PER_BEAT (4),
        .GAP_TICKS      (1),
        .SONG_AW        (3),
        .IDX_W          (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sample n cycles at negedges; bit n-1 of each vector is the first cycle.
    task automatic run(input int n);
        v_valid = '0; v_done = '0; v_play = '0; v_paused = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            v_valid  = {v_valid[62:0],  bus.note_valid};
            v_done   = {v_done[62:0],   bus.done};
            v_play   = {v_play[62:0],   bus.playing};
            v_paused = {v_paused[62:0], bus.paused};
            addr_log[i] = bus.rom_addr;
            code_log[i] = bus.note_code;
        end
    endtask

    task automatic pulse_start(input logic [7:0] idx);
        bus.song_index = idx;
        bus.start      = 1'b1;
        @(posedge clk);
        #1;
        bus.start      = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < 2048; a++) rom[a] = 10'd0;
        rom[0]  = {6'd13, 4'd1};  rom[1]  = {6'd17, 4'd2};              // song 0
        rom[8]  = {6'd0,  4'd1};  rom[9]  = {6'd20, 4'd1};              // song 1
        for (int a = 16; a < 24; a++) rom[a] = {6'd5, 4'd1};            // song 2, no end
        rom[24] = {6'd30, 4'd1};                                        // song 3
        bus.song_index = 8'd0; bus.start = 1'b0; bus.pause = 1'b0; bus.stop = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_valid",  {63'd0, bus.note_valid}, 64'd0);
        chk("rst_play",   {63'd0, bus.playing},    64'd0);
        chk("rst_done",   {63'd0, bus.done},       64'd0);
        chk("rst_paused", {63'd0, bus.paused},     64'd0);
        chk("rst_addr",   {53'd0, bus.rom_addr},   64'd0);
        chk("rst_code",   {58'd0, bus.note_code},  64'd0);
        rst = 1'b0;

        // 1: two notes then end marker
        pulse_start(8'd0);
        run(20);
        chk("t1_valid", {44'd0, v_valid[19:0]}, {44'd0, 20'b00111000111111100000});
        chk("t1_done",  {44'd0, v_done[19:0]},  {44'd0, 20'b00000000000000000010});
        chk("t1_play",  {44'd0, v_play[19:0]},  {44'd0, 20'b11111111111111111100});
        chk("t1_addr0", {53'd0, addr_log[0]},   64'd0);
        chk("t1_addr1", {53'd0, addr_log[6]},   64'd1);
        chk("t1_addr2", {53'd0, addr_log[16]},  64'd2);

        // 2: rest word then a sounding note
        pulse_start(8'd1);
        run(16);
        chk("t2_valid", {48'd0, v_valid[15:0]}, {48'd0, 16'b0000000011100000});
        chk("t2_rest_code", {58'd0, code_log[3]}, 64'd0);
        chk("t2_rest_play", {63'd0, v_play[12]}, 64'd1);
        chk("t2_addr9", {53'd0, addr_log[6]},   64'd9);
        chk("t2_done",  {48'd0, v_done[15:0]},  {48'd0, 16'b0000000000000010});

        // 3: pause mid-note for 10 cycles, then resume
        pulse_start(8'd3);
        run(4);
        chk("t3_pre", {60'd0, v_valid[3:0]}, {60'd0, 4'b0011});
        bus.pause = 1'b1;
        run(1);
        bus.pause = 1'b0;
        chk("t3_paused", {63'd0, v_paused[0]}, 64'd1);
        chk("t3_pvalid", {63'd0, v_valid[0]},  64'd0);
        chk("t3_pplay",  {63'd0, v_play[0]},   64'd0);
        chk("t3_pcode",  {58'd0, code_log[0]}, 64'd30);
        run(9);
        chk("t3_frozen_v", {55'd0, v_valid[8:0]},  64'd0);
        chk("t3_frozen_p", {55'd0, v_paused[8:0]}, {55'd0, 9'b111111111});
        bus.pause = 1'b1;
        run(1);
        bus.pause = 1'b0;
        chk("t3_resume", {62'd0, v_valid[0], v_paused[0]}, {62'd0, 2'b10});
        run(4);
        chk("t3_tail_v", {60'd0, v_valid[3:0]}, 64'd0);
        chk("t3_addr25", {53'd0, addr_log[1]},  64'd25);
        chk("t3_done",   {60'd0, v_done[3:0]},  {60'd0, 4'b0001});

        // 4: stop+start+pause together mid-note, then start song 1
        pulse_start(8'd0);
        run(4);
        bus.stop = 1'b1; bus.start = 1'b1; bus.pause = 1'b1; bus.song_index = 8'd2;
        @(posedge clk);
        #1;
        bus.stop = 1'b0; bus.start = 1'b0; bus.pause = 1'b0;
        run(3);
        chk("t4_valid", {61'd0, v_valid[2:0]},  64'd0);
        chk("t4_play",  {61'd0, v_play[2:0]},   64'd0);
        chk("t4_done",  {61'd0, v_done[2:0]},   64'd0);
        chk("t4_pause", {61'd0, v_paused[2:0]}, 64'd0);
        chk("t4_addr",  {53'd0, addr_log[0]},   64'd0);
        pulse_start(8'd1);
        run(1);
        chk("t4_addr8", {53'd0, addr_log[0]}, 64'd8);
        run(15);
        chk("t4_end", {63'd0, v_play[0]}, 64'd0);

        // 5: eight words with no end marker
        pulse_start(8'd2);
        run(49);
        chk("t5_addr23", {53'd0, addr_log[42]}, 64'd23);
        chk("t5_done1",  64'($countones(v_done[48:0])), 64'd1);
        chk("t5_donepos", {63'd0, v_done[0]}, 64'd1);
        chk("t5_addr16", {53'd0, addr_log[48]}, 64'd16);
`ifdef PLAYER_LOOP_EN
        chk("t5_loop_play", {63'd0, v_play[0]}, 64'd1);
        bus.stop = 1'b1;
        @(posedge clk);
        #1;
        bus.stop = 1'b0;
        run(2);
        chk("t5_stopped", {62'd0, v_play[1:0]}, 64'd0);
`else
        chk("t5_idle", {63'd0, v_play[0]}, 64'd0);
        run(6);
        chk("t5_nowrap_p", {58'd0, v_play[5:0]}, 64'd0);
        chk("t5_nowrap_d", {58'd0, v_done[5:0]}, 64'd0);
`endif

        // 6: asynchronous reset during the gap
        pulse_start(8'd0);
        run(6);
        chk("t6_gap", {62'd0, v_play[0], v_valid[0]}, {62'd0, 2'b10});
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_out", {42'd0, bus.note_valid, bus.playing, bus.paused, bus.done,
                           bus.note_code, bus.rom_addr}, 64'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        run(5);
        chk("t6_idle_p", {59'd0, v_play[4:0]},  64'd0);
        chk("t6_idle_v", {59'd0, v_valid[4:0]}, 64'd0);
        chk("t6_idle_a", {53'd0, addr_log[4]},  64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
